// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle for the data-memory responder.
// master = pipeline MEM stage (initiator), slave = responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      output req_funct3,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      input  req_funct3,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle RV64 data-memory responder (IDLE/BUSY/RESP).
// Optional DMEM_RESP_ERR_CHECK_EN: range/alignment faults raise resp_err.
module dmem_responder #(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   dmem_responder_if.slave  bus
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   typedef struct packed {
      logic        write;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [2:0]  funct3;
   } req_t;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, req_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [63:0] mem_q [DEPTH_WORDS];

   logic [1:0]  size;
   logic        uns;
   logic [2:0]  off_raw;
   logic [2:0]  align_mask;
   logic [2:0]  off;
   logic [AW-1:0] idx;
   logic        err_c;
   logic [63:0] rword;
   logic [63:0] shifted;
   logic [63:0] load_val;
   logic [7:0]  lane;
   logic [7:0]  be;
   logic [63:0] bmask;
   logic [63:0] wshift;
   logic [63:0] merged;
   logic        commit;
   logic        mem_we;

   assign size    = req_q.funct3[1:0];
   assign uns     = req_q.funct3[2];
   assign off_raw = req_q.addr[2:0];

   // Size decode: alignment mask for the offset and base byte-lane pattern.
   always_comb begin
      align_mask = 3'b111;
      lane       = 8'h01;
      unique case (size)
         2'b00: begin align_mask = 3'b111; lane = 8'h01; end
         2'b01: begin align_mask = 3'b110; lane = 8'h03; end
         2'b10: begin align_mask = 3'b100; lane = 8'h0F; end
         2'b11: begin align_mask = 3'b000; lane = 8'hFF; end
      endcase
   end

`ifdef DMEM_RESP_ERR_CHECK_EN
   logic out_of_range;
   logic misaligned;
   assign out_of_range = req_q.addr >= 64'(DEPTH_WORDS * 8);
   assign misaligned   = (off_raw & ~align_mask) != 3'b000;
   assign err_c        = out_of_range || misaligned;
   assign off          = off_raw;
   assign idx          = req_q.addr[AW+2:3];
`else
   // No fault reporting: the index wraps and the offset snaps to size alignment.
   assign err_c = 1'b0;
   assign off   = off_raw & align_mask;
   assign idx   = AW'(req_q.addr[63:3] % 61'(DEPTH_WORDS));
`endif

   assign rword   = mem_q[idx];
   assign shifted = rword >> {off, 3'b000};

   // Load extraction: bring the selected bytes to bit 0, sign- or zero-extend.
   always_comb begin
      load_val = shifted;
      unique case (size)
         2'b00: load_val = uns ? {56'd0, shifted[7:0]}
                               : {{56{shifted[7]}}, shifted[7:0]};
         2'b01: load_val = uns ? {48'd0, shifted[15:0]}
                               : {{48{shifted[15]}}, shifted[15:0]};
         2'b10: load_val = uns ? {32'd0, shifted[31:0]}
                               : {{32{shifted[31]}}, shifted[31:0]};
         2'b11: load_val = shifted;
      endcase
   end

   assign be     = lane << off;
   assign wshift = req_q.wdata << {off, 3'b000};

   // Expand byte enables into a bit mask for the store merge.
   always_comb begin
      bmask = '0;
      for (int b = 0; b < 8; b++) begin
         bmask[b*8 +: 8] = {8{be[b]}};
      end
   end

   assign merged = (rword & ~bmask) | (wshift & bmask);

   assign commit = (state_q == S_BUSY) && (cnt_q == 4'd0);
   assign mem_we = commit && req_q.write && !err_c;

   // FSM next state, request capture, wait counter and response formation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               req_d.write  = bus.req_write;
               req_d.addr   = bus.req_addr;
               req_d.wdata  = bus.req_wdata;
               req_d.funct3 = bus.req_funct3;
               cnt_d        = 4'(WAIT_CYCLES);
               state_d      = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               rdata_d = (req_q.write || err_c) ? 64'd0 : load_val;
               err_d   = err_c;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and response registers; reset abandons any access in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Data array: cleared on reset, merged store committed on BUSY exit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= 64'd0;
         end
      end else if (mem_we) begin
         mem_q[idx] <= merged;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_rdata = rdata_q;
`ifdef DMEM_RESP_ERR_CHECK_EN
   assign bus.resp_err   = err_q;
`else
   assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (WAIT_CYCLES=2).
// Optional DMEM_RESP_ERR_CHECK_EN selects fault-check vectors.
module tb_dmem_responder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH_WORDS (128),
      .WAIT_CYCLES (2)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [2:0] f3);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_funct3 = f3;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int lat;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.resp_valid) break;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd3);
   endtask

   task automatic finish_resp();
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      chk("req_ready_after", {63'd0, bus.req_ready}, 64'd1);
   endtask

   task automatic access(input string tag, input logic w,
                         input logic [63:0] a, input logic [63:0] d,
                         input logic [2:0] f3, input logic [63:0] er,
                         input logic ee);
      send(w, a, d, f3);
      wait_resp(tag);
      chk({tag, "_rdata"}, bus.resp_rdata, er);
      chk({tag, "_err"}, {63'd0, bus.resp_err}, {63'd0, ee});
      finish_resp();
   endtask

   initial begin
      logic [63:0] held;
      checks = 0;
      errors = 0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = 64'd0;
      bus.req_wdata  = 64'd0;
      bus.req_funct3 = 3'd0;
      bus.resp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_rdata", bus.resp_rdata, 64'd0);
      chk("rst_err", {63'd0, bus.resp_err}, 64'd0);

      access("sd10", 1'b1, 64'h10, 64'h8877665544332211, 3'b011,
             64'd0, 1'b0);
      access("ld10", 1'b0, 64'h10, 64'd0, 3'b011,
             64'h8877665544332211, 1'b0);
      access("sb13", 1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 3'b000,
             64'd0, 1'b0);
      access("ld10b", 1'b0, 64'h10, 64'd0, 3'b011,
             64'h88776655AB332211, 1'b0);
      access("lb13", 1'b0, 64'h13, 64'd0, 3'b000,
             64'hFFFFFFFFFFFFFFAB, 1'b0);
      access("lbu13", 1'b0, 64'h13, 64'd0, 3'b100,
             64'h00000000000000AB, 1'b0);
      access("lw14", 1'b0, 64'h14, 64'd0, 3'b010,
             64'hFFFFFFFF88776655, 1'b0);
      access("lwu14", 1'b0, 64'h14, 64'd0, 3'b110,
             64'h0000000088776655, 1'b0);
      access("lh12", 1'b0, 64'h12, 64'd0, 3'b001,
             64'hFFFFFFFFFFFFAB33, 1'b0);
      access("lhu12", 1'b0, 64'h12, 64'd0, 3'b101,
             64'h000000000000AB33, 1'b0);
      access("ldu10", 1'b0, 64'h10, 64'd0, 3'b111,
             64'h88776655AB332211, 1'b0);

      // Backpressure: hold resp_ready low with a second request waiting.
      send(1'b0, 64'h10, 64'd0, 3'b011);
      wait_resp("hold");
      held = bus.resp_rdata;
      chk("hold_rdata0", held, 64'h88776655AB332211);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_addr   = 64'h14;
      bus.req_funct3 = 3'b010;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", {63'd0, bus.resp_valid}, 64'd1);
         chk("hold_rdata", bus.resp_rdata, held);
         chk("hold_ready", {63'd0, bus.req_ready}, 64'd0);
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      chk("rel_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("rel_valid", {63'd0, bus.resp_valid}, 64'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("second_accepted", {63'd0, bus.req_ready}, 64'd0);
      wait_resp("second");
      chk("second_rdata", bus.resp_rdata, 64'hFFFFFFFF88776655);
      finish_resp();

`ifdef DMEM_RESP_ERR_CHECK_EN
      access("sw12_err", 1'b1, 64'h12, 64'h1234_5678, 3'b010,
             64'd0, 1'b1);
      access("ld10_unch", 1'b0, 64'h10, 64'd0, 3'b011,
             64'h88776655AB332211, 1'b0);
      access("ld400_err", 1'b0, 64'h400, 64'd0, 3'b011,
             64'd0, 1'b1);
`else
      access("ld410_wrap", 1'b0, 64'h410, 64'd0, 3'b011,
             64'h88776655AB332211, 1'b0);
      access("lw16_align", 1'b0, 64'h16, 64'd0, 3'b110,
             64'h0000000088776655, 1'b0);
`endif

      // Reset in BUSY abandons an uncommitted store and clears the array.
      send(1'b1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 3'b011);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("midrst_valid", {63'd0, bus.resp_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("postrst_ready", {63'd0, bus.req_ready}, 64'd1);
      access("ld20_rst", 1'b0, 64'h20, 64'd0, 3'b011, 64'd0, 1'b0);
      access("ld10_rst", 1'b0, 64'h10, 64'd0, 3'b011, 64'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
